dco_freq_ctrl: RTL

DCO_FREQ_CTRL -- requirements
Module: dco_freq_ctrl

---
 rtl/dco_freq_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/dco_freq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dco_freq_ctrl: two-phase SAR calibration of a DCO against a CLK window.  |
// | Optional DCO_FREQ_CTRL_TRACK_EN: fine-code tracking while locked.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dco_freq_ctrl #(
  parameter int SETTLE_CYC = 16,
  parameter int CNT_W      = 12
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [CNT_W-1:0] TARGET,
  input  logic [9:0]       WINDOW,
  input  logic [3:0]       TOL,
  input  logic             DIV_CLK_IN,
  output logic [5:0]       DCO_SEL,
  output logic [6:0]       EN_CAP,
  output logic             CLK_RSTN,
  output logic             BUSY,
  output logic             LOCKED,
  output logic             FAIL,
  output logic [CNT_W-1:0] MEAS_CNT
);

  localparam int c_SETTLE_EFF = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
  localparam int c_TMR_W      = (c_SETTLE_EFF > 1024) ? $clog2(c_SETTLE_EFF) : 10;
  localparam int c_XW         = CNT_W + 1;
  localparam logic [c_TMR_W-1:0] c_SETTLE_LAST = c_TMR_W'(c_SETTLE_EFF - 1);
  localparam logic [3:0]         c_FINAL_STEP  = 4'd12;
  localparam logic [5:0]         c_MID         = 6'b100000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_DECIDE  = 3'd3,
    ST_LOCK    = 3'd4,
    ST_FAIL    = 3'd5
  } state_t;

  state_t             r_state, w_next;
  logic               r_sync1, r_sync2, r_hist;
  logic [CNT_W-1:0]   r_cnt, r_meas;
  logic [c_TMR_W-1:0] r_timer;
  logic [3:0]         r_step;
  logic [5:0]         r_sel, r_en;
  logic               r_clk_rstn, r_busy, r_locked, r_fail;

  logic               w_edge, w_settle_done, w_win_done, w_keep, w_in_tol, w_start_ok;
  logic [CNT_W-1:0]   w_cnt_inc, w_diff;
  logic [c_TMR_W-1:0] w_win_last;
  logic [2:0]         w_pos;
  logic [5:0]         w_mask, w_sel_upd, w_en_upd;

  assign w_edge        = r_sync2 & ~r_hist;
  assign w_cnt_inc     = (w_edge && (r_cnt != '1)) ? r_cnt + 1'b1 : r_cnt;
  assign w_win_last    = (WINDOW == 10'd0) ? '0 : c_TMR_W'(WINDOW - 10'd1);
  assign w_settle_done = (r_timer == c_SETTLE_LAST);
  assign w_win_done    = (r_timer == w_win_last);
  assign w_keep        = (r_meas >= TARGET);
  assign w_diff        = w_keep ? (r_meas - TARGET) : (TARGET - r_meas);
  assign w_in_tol      = (w_diff <= CNT_W'(TOL));
  assign w_start_ok    = START && ((r_state == ST_IDLE) || (r_state == ST_LOCK) ||
                                   (r_state == ST_FAIL));

  // Steps 0-5 walk DCO_SEL bits 5..0, steps 6-11 walk the fine code bits 5..0.
  assign w_pos     = (r_step < 4'd6) ? r_step[2:0] : 3'(r_step - 4'd6);
  assign w_mask    = c_MID >> w_pos;
  assign w_sel_upd = (w_keep ? r_sel : (r_sel & ~w_mask)) | (w_mask >> 1);
  assign w_en_upd  = (w_keep ? r_en  : (r_en  & ~w_mask)) | (w_mask >> 1);

`ifdef DCO_FREQ_CTRL_TRACK_EN
  logic [c_XW-1:0] w_cnt_x, w_tgt_x, w_tol_x;
  logic            w_hi, w_lo, w_track_oob;
  assign w_cnt_x     = {1'b0, w_cnt_inc};
  assign w_tgt_x     = {1'b0, TARGET};
  assign w_tol_x     = c_XW'(TOL);
  assign w_hi        = w_cnt_x > (w_tgt_x + w_tol_x);
  assign w_lo        = (w_cnt_x + w_tol_x) < w_tgt_x;
  assign w_track_oob = (w_hi && (r_en == 6'h3F)) || (w_lo && (r_en == 6'h00));
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_FAIL: if (START) w_next = ST_SETTLE;
      ST_SETTLE:        if (w_settle_done) w_next = ST_MEASURE;
      ST_MEASURE:       if (w_win_done) w_next = ST_DECIDE;
      ST_DECIDE: begin
        if (r_step != c_FINAL_STEP) w_next = ST_SETTLE;
        else if (w_in_tol)          w_next = ST_LOCK;
        else                        w_next = ST_FAIL;
      end
      ST_LOCK: begin
        if (START) w_next = ST_SETTLE;
`ifdef DCO_FREQ_CTRL_TRACK_EN
        else if (w_win_done && w_track_oob) w_next = ST_FAIL;
`endif
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_hist     <= 1'b0;
      r_cnt      <= '0;
      r_meas     <= '0;
      r_timer    <= '0;
      r_step     <= '0;
      r_sel      <= '0;
      r_en       <= '0;
      r_clk_rstn <= 1'b0;
      r_busy     <= 1'b0;
      r_locked   <= 1'b0;
      r_fail     <= 1'b0;
    end else begin
      r_sync1 <= DIV_CLK_IN;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      if (w_start_ok) begin
        r_timer    <= '0;
        r_cnt      <= '0;
        r_step     <= '0;
        r_sel      <= c_MID;
        r_en       <= c_MID;
        r_clk_rstn <= 1'b1;
        r_busy     <= 1'b1;
        r_locked   <= 1'b0;
        r_fail     <= 1'b0;
      end else begin
        case (r_state)
          ST_SETTLE: begin
            if (w_settle_done) begin
              r_timer <= '0;
              r_cnt   <= '0;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          ST_MEASURE: begin
            r_cnt <= w_cnt_inc;
            if (w_win_done) begin
              r_timer <= '0;
              r_meas  <= w_cnt_inc;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          ST_DECIDE: begin
            r_cnt  <= '0;
            r_step <= r_step + 4'd1;
            if (r_step < 4'd6) begin
              r_sel <= w_sel_upd;
            end else if (r_step < c_FINAL_STEP) begin
              r_en <= w_en_upd;
            end else begin
              r_busy   <= 1'b0;
              r_locked <= w_in_tol;
              r_fail   <= ~w_in_tol;
            end
          end
`ifdef DCO_FREQ_CTRL_TRACK_EN
          // Back-to-back windows; the fine code nudges one LSB per window.
          ST_LOCK: begin
            if (w_win_done) begin
              r_timer <= '0;
              r_cnt   <= '0;
              r_meas  <= w_cnt_inc;
              if (w_track_oob) begin
                r_locked <= 1'b0;
                r_fail   <= 1'b1;
              end else if (w_hi) begin
                r_en <= r_en + 6'd1;
              end else if (w_lo) begin
                r_en <= r_en - 6'd1;
              end
            end else begin
              r_timer <= r_timer + 1'b1;
              r_cnt   <= w_cnt_inc;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign DCO_SEL  = r_sel;
  assign EN_CAP   = {r_en, 1'b0};
  assign CLK_RSTN = r_clk_rstn;
  assign BUSY     = r_busy;
  assign LOCKED   = r_locked;
  assign FAIL     = r_fail;
  assign MEAS_CNT = r_meas;

endmodule
`default_nettype wire
